// File: rtl/cavlc_bitstream_window_if.sv
// Bitstream window bus: word refill handshake from the fetch stage, consume
// feedback from the length decoder, and the window/status outputs.
interface cavlc_bitstream_window_if #(
    parameter int POS_W = 32
);
    logic [15:0]      word_in;
    logic             word_valid;
    logic             word_ready;
    logic             consume_en;
    logic [4:0]       cavlc_consumed_bits_len;
    logic             flush;
    logic [15:0]      BitStream_buffer_output;
    logic             window_valid;
    logic [6:0]       fill_level;
    logic [POS_W-1:0] bit_pos;
    logic             len_err;

    modport master (
        output word_in, word_valid, consume_en, cavlc_consumed_bits_len, flush,
        input  word_ready, BitStream_buffer_output, window_valid, fill_level,
               bit_pos, len_err
    );

    modport slave (
        input  word_in, word_valid, consume_en, cavlc_consumed_bits_len, flush,
        output word_ready, BitStream_buffer_output, window_valid, fill_level,
               bit_pos, len_err
    );
endinterface

// File: rtl/cavlc_bitstream_window.sv
// MSB-aligned bit-window buffer feeding the CAVLC length decoder: refills in
// 16-bit words, advances by the consumed length each cycle.
module cavlc_bitstream_window #(
    parameter int BUF_W = 64,
    parameter int POS_W = 32
) (
    input  logic clk,
    input  logic reset_n,
    cavlc_bitstream_window_if.slave bs
);
    logic [BUF_W-1:0] buf_q;
    logic [6:0]       fill_q;
    logic [POS_W-1:0] pos_q;
    logic             err_q;

    logic [6:0]       len7;
    logic             win_valid;
    logic             ready;
    logic             legal;
    logic             illegal;
    logic             acc;
    logic [6:0]       shamt;
    logic [6:0]       remaining;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] inserted;
    logic [BUF_W-1:0] buf_next;
    logic [6:0]       fill_next;

    assign len7      = {2'b00, bs.cavlc_consumed_bits_len};
    assign win_valid = (fill_q >= 7'd16);
    assign ready     = (fill_q <= 7'(BUF_W - 16));

    // len <= 16 together with len <= fill covers both the full-window case
    // (fill >= 16) and the end-of-stream tail drain.
    assign legal   = bs.consume_en && (len7 <= 7'd16) && (len7 <= fill_q);
    assign illegal = bs.consume_en && !legal;
    assign acc     = bs.word_valid && ready;

    assign shamt     = legal ? len7 : 7'd0;
    assign remaining = fill_q - shamt;
    assign shifted   = buf_q << shamt;

    // Bits below the valid region are always zero, so the new word can be
    // OR-ed in directly behind the surviving bits.
    assign inserted  = {bs.word_in, {(BUF_W-16){1'b0}}} >> remaining;
    assign buf_next  = acc ? (shifted | inserted) : shifted;
    assign fill_next = remaining + (acc ? 7'd16 : 7'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q  <= '0;
            fill_q <= '0;
            pos_q  <= '0;
            err_q  <= 1'b0;
        end else if (bs.flush) begin
            buf_q  <= '0;
            fill_q <= '0;
            pos_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            buf_q  <= buf_next;
            fill_q <= fill_next;
            pos_q  <= pos_q + POS_W'(shamt);
            if (illegal)
                err_q <= 1'b1;
        end
    end

    assign bs.BitStream_buffer_output = buf_q[BUF_W-1 -: 16];
    assign bs.window_valid            = win_valid;
    assign bs.word_ready              = ready;
    assign bs.fill_level              = fill_q;
    assign bs.bit_pos                 = pos_q;
    assign bs.len_err                 = err_q;
endmodule

// File: tb/tb_cavlc_bitstream_window.sv
// Scoreboard bench for cavlc_bitstream_window: a bit-queue reference model
// predicts each cycle's outputs; a monitor compares after every edge.
module tb_cavlc_bitstream_window;
    localparam int BUF_W = 64;
    localparam int POS_W = 32;

    typedef struct packed {
        logic [15:0] win;
        logic [6:0]  fill;
        logic [31:0] pos;
        logic        err;
        logic        wvalid;
        logic        wready;
    } obs_t;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    cavlc_bitstream_window_if #(.POS_W(POS_W)) bs ();

    cavlc_bitstream_window #(.BUF_W(BUF_W), .POS_W(POS_W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bs     (bs.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the buffered stream as a queue of bits, oldest first.
    bit          mq[$];
    logic [31:0] mpos;
    logic        merr;
    obs_t        expq[$];

    function automatic obs_t model_obs();
        obs_t o;
        for (int i = 0; i < 16; i++)
            o.win[15-i] = (i < mq.size()) ? mq[i] : 1'b0;
        o.fill   = 7'(mq.size());
        o.pos    = mpos;
        o.err    = merr;
        o.wvalid = (mq.size() >= 16);
        o.wready = (mq.size() <= BUF_W - 16);
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic wv, input logic [15:0] w, input logic ce,
                        input logic [4:0] len, input logic fl);
        int  fill;
        bit  can_take;
        @(negedge clk);
        bs.word_valid = wv;
        bs.word_in = w;
        bs.consume_en = ce;
        bs.cavlc_consumed_bits_len = len;
        bs.flush = fl;
        fill = mq.size();
        can_take = (fill <= BUF_W - 16);
        if (fl) begin
            mq.delete();
            mpos = '0;
            merr = 1'b0;
        end else begin
            if (ce) begin
                if (len > 16 || (fill < 16 && int'(len) > fill)) begin
                    merr = 1'b1;
                end else begin
                    for (int i = 0; i < int'(len); i++) void'(mq.pop_front());
                    mpos = mpos + 32'(len);
                end
            end
            if (wv && can_take)
                for (int i = 15; i >= 0; i--) mq.push_back(w[i]);
        end
        expq.push_back(model_obs());
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected observation per stepped cycle.
    always @(posedge clk) begin
        obs_t act, exp;
        #1;
        if (reset_n && expq.size() > 0) begin
            exp = expq.pop_front();
            act.win    = bs.BitStream_buffer_output;
            act.fill   = bs.fill_level;
            act.pos    = bs.bit_pos;
            act.err    = bs.len_err;
            act.wvalid = bs.window_valid;
            act.wready = bs.word_ready;
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL scoreboard @%0t: got win=%h fill=%0d pos=%0d err=%b wv=%b wr=%b, expected win=%h fill=%0d pos=%0d err=%b wv=%b wr=%b",
                         $time, act.win, act.fill, act.pos, act.err, act.wvalid, act.wready,
                         exp.win, exp.fill, exp.pos, exp.err, exp.wvalid, exp.wready);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " window"}, 32'(bs.BitStream_buffer_output), 32'h0);
        chk({tag, " fill"}, 32'(bs.fill_level), 32'd0);
        chk({tag, " bit_pos"}, bs.bit_pos, 32'd0);
        chk({tag, " len_err"}, 32'(bs.len_err), 32'd0);
        chk({tag, " window_valid"}, 32'(bs.window_valid), 32'd0);
        chk({tag, " word_ready"}, 32'(bs.word_ready), 32'd1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        mpos = '0;
        merr = 1'b0;
        reset_n = 1'b0;
        bs.word_valid = 1'b0;
        bs.word_in = '0;
        bs.consume_en = 1'b0;
        bs.cavlc_consumed_bits_len = '0;
        bs.flush = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Two back-to-back words, then a 4-bit consume.
        step(1, 16'hA5C3, 0, 0, 0);
        step(1, 16'h1234, 0, 0, 0);
        settle();
        chk("fill2 window", 32'(bs.BitStream_buffer_output), 32'hA5C3);
        chk("fill2 fill", 32'(bs.fill_level), 32'd32);
        chk("fill2 valid", 32'(bs.window_valid), 32'd1);
        chk("fill2 pos", bs.bit_pos, 32'd0);
        step(0, 16'h0, 1, 5'd4, 0);
        settle();
        chk("c4 window", 32'(bs.BitStream_buffer_output), 32'h5C31);
        chk("c4 fill", 32'(bs.fill_level), 32'd28);
        chk("c4 pos", bs.bit_pos, 32'd4);

        // Bring level to 20, then consume 16 and refill in the same cycle.
        step(0, 16'h0, 1, 5'd8, 0);
        settle();
        chk("c8 window", 32'(bs.BitStream_buffer_output), 32'h3123);
        step(1, 16'hFFFF, 1, 5'd16, 0);
        settle();
        chk("simul window", 32'(bs.BitStream_buffer_output), 32'h4FFF);
        chk("simul fill", 32'(bs.fill_level), 32'd20);
        chk("simul pos", bs.bit_pos, 32'd28);

        // Fill to capacity; a held word waits until the level drops to 48.
        step(0, 16'h0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 16'(16'h1111 * (i + 1)), 0, 0, 0);
        settle();
        chk("fill48 ready", 32'(bs.word_ready), 32'd1);
        step(1, 16'h4444, 0, 0, 0);
        settle();
        chk("full fill", 32'(bs.fill_level), 32'd64);
        chk("full ready", 32'(bs.word_ready), 32'd0);
        step(1, 16'h5555, 0, 0, 0);
        settle();
        chk("held fill", 32'(bs.fill_level), 32'd64);
        step(1, 16'h5555, 1, 5'd16, 0);
        settle();
        chk("drain fill", 32'(bs.fill_level), 32'd48);
        chk("drain window", 32'(bs.BitStream_buffer_output), 32'h2222);
        step(1, 16'h5555, 0, 0, 0);
        settle();
        chk("refill fill", 32'(bs.fill_level), 32'd64);

        // Over-long consume sets the sticky error; flush clears it.
        step(0, 16'h0, 0, 0, 1);
        step(1, 16'hBEEF, 0, 0, 0);
        step(1, 16'hCAFE, 0, 0, 0);
        step(0, 16'h0, 1, 5'd17, 0);
        settle();
        chk("len17 err", 32'(bs.len_err), 32'd1);
        chk("len17 fill", 32'(bs.fill_level), 32'd32);
        chk("len17 window", 32'(bs.BitStream_buffer_output), 32'hBEEF);
        step(0, 16'h0, 0, 0, 1);
        settle();
        chk("flush err", 32'(bs.len_err), 32'd0);
        chk("flush fill", 32'(bs.fill_level), 32'd0);
        chk("flush pos", bs.bit_pos, 32'd0);

        // Tail drain below a full window.
        step(1, 16'h8001, 0, 0, 0);
        step(0, 16'h0, 1, 5'd11, 0);
        step(0, 16'h0, 1, 5'd5, 0);
        settle();
        chk("tail fill", 32'(bs.fill_level), 32'd0);
        chk("tail err", 32'(bs.len_err), 32'd0);
        chk("tail pos", bs.bit_pos, 32'd16);
        step(0, 16'h0, 1, 5'd1, 0);
        settle();
        chk("empty err", 32'(bs.len_err), 32'd1);

        // Asynchronous reset mid-stream.
        step(1, 16'h1357, 0, 0, 0);
        step(1, 16'h2468, 1, 5'd3, 0);
        @(posedge clk);
        #3;
        bs.word_valid = 1'b0;
        bs.consume_en = 1'b0;
        bs.flush = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        mq.delete();
        mpos = '0;
        merr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic       wv, ce, fl;
            logic [4:0] len;
            wv  = ($urandom_range(0, 9) < 7);
            ce  = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 99) < 2);
            len = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(17, 31))
                                               : 5'($urandom_range(0, 16));
            step(wv, 16'($urandom), ce, len, fl);
        end
        step(0, 16'h0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drained", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cavlc_bitstream_window.md
Name: cavlc_bitstream_window

Overview:
- Bit-window buffer that sits directly upstream of the CAVLC consumed-bits length decoder.
- Accepts 16-bit bitstream words from the fetch stage and presents a 16-bit MSB-aligned window, BitStream_buffer_output, to the CAVLC parsing logic.
- Each cycle it advances by the consumed-bit length fed back from the length decoder.
- Tracks fill level, a running bit position and a sticky overrun error.

Parameters:
- BUF_W, 64, internal shift buffer width in bits; must be a multiple of 16 and at least 32.
- POS_W, 32, width of the consumed-bit position counter.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- word_in  input  16  next bitstream word, first bit in bit 15
- word_valid  input  1  word_in is valid
- word_ready  output  1  buffer can accept word_in this cycle
- consume_en  input  1  advance window this cycle
- cavlc_consumed_bits_len  input  5  bits to discard from window head (legal range 0..16)
- flush  input  1  synchronous discard of all buffered bits (slice start / resync)
- BitStream_buffer_output  output  16  window, oldest bit in bit 15
- window_valid  output  1  fill level is at least 16
- fill_level  output  7  buffered valid bits, 0..BUF_W
- bit_pos  output  POS_W  total bits consumed since reset or flush
- len_err  output  1  sticky illegal-consume flag

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - buffer = 0, fill_level = 0, bit_pos = 0, len_err = 0.
  - BitStream_buffer_output = 0, window_valid = 0, word_ready = 1.
- Storage: buffer is MSB-aligned; valid bits occupy buf[BUF_W-1 : BUF_W-fill_level]. Bits below the valid region are don't-care internally but are driven to 0.
- Window outputs:
  - BitStream_buffer_output = buf[BUF_W-1 : BUF_W-16], combinational from registers.
  - window_valid = (fill_level >= 16).
  - Bits beyond fill_level within the window read 0.
- Refill handshake:
  - word_ready = (fill_level <= BUF_W-16), computed from the registered level only; it has no combinational path from consume_en.
  - A word is accepted when word_valid && word_ready.
- Consume legality:
  - A consume is legal when consume_en, window_valid, and len <= 16.
  - Illegal cases are consume_en with len > 16, or consume_en with window_valid = 0 and len > fill_level.
  - On an illegal consume: set len_err (sticky until reset or flush); no shift; bit_pos unchanged. A word refill in the same cycle still proceeds.
  - consume_en with len = 0 is a legal no-op.
  - With window_valid = 0 and len <= fill_level, the consume is legal. This drains the tail at end of stream.
- Next-state update, single cycle, with acc = word accepted and L = len if the consume is legal, else 0:
  - remaining = fill_level - L; buffer shifted left by L, zero-filled.
  - If acc: word_in is written at buf[BUF_W-1-remaining : BUF_W-16-remaining].
  - fill_level' = remaining + (acc ? 16 : 0).
  - bit_pos' = bit_pos + L, wrapping modulo 2^POS_W.
- Simultaneous consume and refill:
  - Both apply in the same cycle; the consume is ordered before the insert.
  - The new word lands contiguous after the surviving bits.
  - Worst case fill_level = BUF_W-16 with no consume, plus accept, gives BUF_W; no overflow is possible.
- Latency: a consume in cycle N is visible in BitStream_buffer_output in cycle N+1. A word accepted in cycle N is visible in N+1.
- Flush:
  - Clears buffer, fill_level, bit_pos and len_err on the next edge.
  - Flush has priority over consume and refill in the same cycle. word_ready stays at its registered value, but a word accepted during flush is discarded.
- Reset mid-operation: all state returns to reset values immediately and asynchronously; no partial word is retained.
- Widths: all level arithmetic is 7-bit unsigned; len is zero-extended; the subtraction cannot underflow because of the legality check.

Test Plan:
- Reset, then feed 0xA5C3 then 0x1234 back-to-back -> after the 2nd edge fill_level = 32, BitStream_buffer_output = 0xA5C3, window_valid = 1, bit_pos = 0.
- With 0xA5C3,0x1234 buffered, consume len = 4 -> next cycle output = 0x5C31, fill_level = 28, bit_pos = 4.
- Same cycle: consume len = 16 and accept 0xFFFF with fill_level = 20 -> fill_level = 20, window = old bits 16..19 followed by 0xFFF, no gap.
- Fill to 48, hold word_valid -> one more word accepted (fill_level = 64, word_ready = 0); a further word is held until a consume brings fill_level <= 48.
- consume_en with len = 17 at fill_level = 32 -> len_err = 1, fill_level stays 32, window unchanged; a subsequent flush clears len_err, fill_level and bit_pos to 0.
- Tail drain: fill_level = 5, consume len = 5 -> accepted, fill_level = 0; then len = 1 at fill_level = 0 -> len_err = 1. Also assert reset_n mid-stream -> outputs return to reset values without waiting for a clk edge.
